// File: rtl/countdown_ctrl_pkg.sv
// Shared encodings for the countdown-timer controller and the BCD down-counter.
package countdown_ctrl_pkg;

    localparam int unsigned DIGIT_W = 4;

    // Counter command; the counter decodes the same values.
    typedef enum logic [1:0] {
        CMD_IDLE     = 2'd0,
        CMD_STOP     = 2'd1,
        CMD_COUNTING = 2'd2
    } cnt_cmd_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSE  = 2'd2,
        S_FINISH = 2'd3
    } state_e;

    // Two-digit BCD count as fed back from the counter.
    typedef struct packed {
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] units;
    } bcd_count_t;

    function automatic logic is_zero(input bcd_count_t c);
        return (c.tens == '0) && (c.units == '0);
    endfunction

endpackage

// File: rtl/countdown_ctrl_if.sv
// Controller-side bundle: button levels, counter feedback and counter command/status.
interface countdown_ctrl_if;
    import countdown_ctrl_pkg::*;

    logic               btn_start;
    logic               btn_clear;
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] units;
    cnt_cmd_e           cnt_state;
    logic               running;
    logic               alarm;
    logic               tick;

    // Environment side: buttons and counter.
    modport master (
        output btn_start, btn_clear, tens, units,
        input  cnt_state, running, alarm, tick
    );

    // Controller side.
    modport slave (
        input  btn_start, btn_clear, tens, units,
        output cnt_state, running, alarm, tick
    );
endinterface

// File: rtl/countdown_ctrl_tick_gen.sv
// Prescaler producing one tick every TICK_DIV enabled cycles; holds its phase when disabled.
module countdown_ctrl_tick_gen #(
    parameter int unsigned TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int unsigned     CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Wrap pulse only while counting.
    assign tick = en & (cnt_q == LAST);

    // Prescaler: clear wins, otherwise count and wrap while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/countdown_ctrl.sv
// Sequencing controller for the two-digit BCD countdown timer.
module countdown_ctrl
    import countdown_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 100000000,
    parameter int unsigned ALARM_TICKS = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    countdown_ctrl_if.slave  bus
);
    localparam int unsigned ALARM_W = (ALARM_TICKS > 0) ? $clog2(ALARM_TICKS + 1) : 1;

    state_e             state_q;
    state_e             state_d;
    cnt_cmd_e           cmd;
    logic               start_q;
    logic               clear_q;
    logic               armed_q;
    logic               start_p;
    logic               clear_p;
    logic               tick;
    logic               count_zero;
    logic               alarm_open;
    logic [ALARM_W-1:0] alarm_cnt_q;
    bcd_count_t         count;

    assign count      = '{tens: bus.tens, units: bus.units};
    assign count_zero = is_zero(count);
    assign alarm_open = alarm_cnt_q < ALARM_W'(ALARM_TICKS);

    // Rising-edge detect; a button already high when reset releases is not a press.
    assign start_p = armed_q & bus.btn_start & ~start_q;
    assign clear_p = armed_q & bus.btn_clear & ~clear_q;

    // Previous button levels and post-reset arming flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            clear_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            start_q <= bus.btn_start;
            clear_q <= bus.btn_clear;
            armed_q <= 1'b1;
        end
    end

    // Time base runs while counting or alarming, keeps its phase while paused.
    countdown_ctrl_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    ((state_q == S_RUN) || (state_q == S_FINISH)),
        .clr   (state_q == S_IDLE),
        .tick  (tick)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and counter command; COUNTING only on a tick that stays in S_RUN.
    always_comb begin
        state_d = state_q;
        cmd     = CMD_STOP;
        case (state_q)
            S_IDLE: begin
                cmd = CMD_IDLE;
                if (start_p) state_d = S_RUN;
            end
            S_RUN: begin
                if (count_zero)   state_d = S_FINISH;
                else if (start_p) state_d = S_PAUSE;
                else if (tick)    cmd     = CMD_COUNTING;
            end
            S_PAUSE: begin
                if (start_p) state_d = S_RUN;
            end
            S_FINISH: begin
                if (start_p) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (clear_p) begin
            state_d = S_IDLE;
            if (cmd == CMD_COUNTING) cmd = CMD_STOP;
        end
    end

    // Alarm duration: restart on entry to S_FINISH, count ticks up to the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_cnt_q <= '0;
        end else if ((state_d == S_FINISH) && (state_q != S_FINISH)) begin
            alarm_cnt_q <= '0;
        end else if ((state_q == S_FINISH) && tick && alarm_open) begin
            alarm_cnt_q <= alarm_cnt_q + ALARM_W'(1);
        end
    end

    assign bus.cnt_state = cmd;
    assign bus.running   = (state_q == S_RUN);
    assign bus.alarm     = (state_q == S_FINISH) && alarm_open;
    assign bus.tick      = tick;
endmodule
